ioctl_cart_loader: RTL

Parametrised cartridge/ROM download engine between `hps_io`'s ioctl byte stream and a word-wide memory write port in the core clock domain. It accepts downloads for up to NSLOT consecutive ioctl indices and packs bytes little-endian into DW-bit words with byte enables. It backpressures the HPS through `ioctl_wait` while the memory port stalls, and reports per-slot load status, image size and a power-of-two mirror mask for cartridge address decoding.

---
 rtl/ioctl_cart_loader.sv | 255 +++++++++++++++++++++++++
 1 files changed

// File: rtl/ioctl_cart_loader.sv
// rtl/ioctl_cart_loader.sv - ioctl byte stream to word-wide memory download engine
module ioctl_cart_loader #(
    parameter int DW         = 8,
    parameter int AW         = 14,
    parameter int NSLOT      = 1,
    parameter int INDEX_BASE = 1
) (
    input  logic                                   clk,
    input  logic                                   reset,
    input  logic                                   ioctl_download,
    input  logic [7:0]                             ioctl_index,
    input  logic                                   ioctl_wr,
    input  logic [24:0]                            ioctl_addr,
    input  logic [7:0]                             ioctl_dout,
    output logic                                   ioctl_wait,
    output logic                                   mem_we,
    input  logic                                   mem_ready,
    output logic [AW-1:0]                          mem_addr,
    output logic [DW-1:0]                          mem_din,
    output logic [DW/8-1:0]                        mem_be,
    output logic [((NSLOT > 1) ? $clog2(NSLOT) : 1)-1:0] mem_slot,
    output logic                                   busy,
    output logic                                   done,
    output logic [NSLOT-1:0]                       loaded,
    output logic [AW+$clog2(DW/8):0]               cart_size,
    output logic [AW-1:0]                          mirror_mask,
    output logic                                   overflow
);

    localparam int L   = DW / 8;
    localparam int LB  = $clog2(L);
    localparam int SW  = (NSLOT > 1) ? $clog2(NSLOT) : 1;
    localparam int CSW = AW + LB + 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PACK  = 3'd1,
        S_WRITE = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t          state_q, state_d;
    logic            dl_prev_q;
    logic [DW-1:0]   data_q, data_d;
    logic [L-1:0]    fill_q, fill_d;
    logic [AW-1:0]   waddr_q, waddr_d;
    logic            skid_v_q, skid_v_d;
    logic [2:0]      skid_lane_q, skid_lane_d;
    logic [7:0]      skid_byte_q, skid_byte_d;
    logic [AW-1:0]   skid_addr_q, skid_addr_d;
    logic            end_q, end_d;
    logic [SW-1:0]   slot_q, slot_d;
    logic [NSLOT-1:0] loaded_q, loaded_d;
    logic [CSW-1:0]  cart_q, cart_d;
    logic [AW-1:0]   mask_q, mask_d;
    logic            ovf_q, ovf_d;

    logic [24:0]     word_full;
    logic            in_range;
    logic [AW-1:0]   word_addr;
    logic [2:0]      lane;
    logic [L-1:0]    lane_bit;
    logic [L-1:0]    skid_bit;
    logic [CSW-1:0]  addr_p1;
    logic [31:0]     idx32;
    logic            idx_ok;
    logic            dl_low;

    // Insert one byte into its lane, leaving the other lanes untouched.
    function automatic logic [DW-1:0] put_byte(input logic [DW-1:0] word,
                                               input logic [2:0]    ln,
                                               input logic [7:0]    b);
        logic [5:0] sh;
        sh = {ln, 3'b000};
        return (word & ~(DW'(8'hFF) << sh)) | (DW'(b) << sh);
    endfunction

    // Word-address mirror mask: bit-smear of (word count - 1).
    function automatic logic [AW-1:0] calc_mask(input logic [CSW-1:0] size);
        logic [CSW-1:0] words;
        logic [CSW-1:0] m;
        words = (size + CSW'(L - 1)) >> LB;
        m = (words == '0) ? '0 : words - CSW'(1);
        for (int i = 1; i < CSW; i++) begin
            m = m | (m >> i);
        end
        return AW'(m);
    endfunction

    assign word_full = ioctl_addr >> LB;
    assign in_range  = ((word_full >> AW) == '0);
    assign word_addr = AW'(word_full);
    assign lane      = 3'(ioctl_addr & 25'(L - 1));
    assign lane_bit  = L'(1) << lane;
    assign skid_bit  = L'(1) << skid_lane_q;
    assign addr_p1   = CSW'(ioctl_addr) + CSW'(1);
    assign idx32     = {24'd0, ioctl_index};
    assign idx_ok    = (idx32 >= 32'(INDEX_BASE)) && (idx32 < 32'(INDEX_BASE + NSLOT));
    assign dl_low    = ~ioctl_download;

    // State and datapath registers; dl_prev resets high so a download already
    // running at reset release is not mistaken for a new one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            dl_prev_q   <= 1'b1;
            data_q      <= '0;
            fill_q      <= '0;
            waddr_q     <= '0;
            skid_v_q    <= 1'b0;
            skid_lane_q <= '0;
            skid_byte_q <= '0;
            skid_addr_q <= '0;
            end_q       <= 1'b0;
            slot_q      <= '0;
            loaded_q    <= '0;
            cart_q      <= '0;
            mask_q      <= '0;
            ovf_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dl_prev_q   <= ioctl_download;
            data_q      <= data_d;
            fill_q      <= fill_d;
            waddr_q     <= waddr_d;
            skid_v_q    <= skid_v_d;
            skid_lane_q <= skid_lane_d;
            skid_byte_q <= skid_byte_d;
            skid_addr_q <= skid_addr_d;
            end_q       <= end_d;
            slot_q      <= slot_d;
            loaded_q    <= loaded_d;
            cart_q      <= cart_d;
            mask_q      <= mask_d;
            ovf_q       <= ovf_d;
        end
    end

    // Next-state and datapath update: packing, skid handling, end-of-download.
    always_comb begin
        state_d     = state_q;
        data_d      = data_q;
        fill_d      = fill_q;
        waddr_d     = waddr_q;
        skid_v_d    = skid_v_q;
        skid_lane_d = skid_lane_q;
        skid_byte_d = skid_byte_q;
        skid_addr_d = skid_addr_q;
        end_d       = end_q;
        slot_d      = slot_q;
        loaded_d    = loaded_q;
        cart_d      = cart_q;
        mask_d      = mask_q;
        ovf_d       = ovf_q;
        case (state_q)
            S_IDLE: begin
                if (ioctl_download && !dl_prev_q && idx_ok) begin
                    slot_d           = SW'(idx32 - 32'(INDEX_BASE));
                    loaded_d[slot_d] = 1'b0;
                    cart_d           = '0;
                    ovf_d            = 1'b0;
                    data_d           = '0;
                    fill_d           = '0;
                    skid_v_d         = 1'b0;
                    end_d            = 1'b0;
                    state_d          = S_PACK;
                end
            end
            S_PACK: begin
                end_d = dl_low;
                if (ioctl_wr && in_range) begin
                    if (addr_p1 > cart_q) begin
                        cart_d = addr_p1;
                    end
                    if (fill_q == '0 || word_addr == waddr_q) begin
                        data_d  = put_byte(data_q, lane, ioctl_dout);
                        fill_d  = fill_q | lane_bit;
                        waddr_d = word_addr;
                        if (fill_d == '1) begin
                            state_d = S_WRITE;
                        end else if (dl_low) begin
                            state_d = S_FLUSH;
                        end
                    end else begin
                        skid_v_d    = 1'b1;
                        skid_lane_d = lane;
                        skid_byte_d = ioctl_dout;
                        skid_addr_d = word_addr;
                        state_d     = S_WRITE;
                    end
                end else begin
                    if (ioctl_wr) begin
                        ovf_d = 1'b1;
                    end
                    if (dl_low) begin
                        state_d = (fill_q != '0) ? S_FLUSH : S_DONE;
                    end
                end
            end
            S_WRITE: begin
                end_d = end_q | dl_low;
                if (mem_ready) begin
                    data_d = '0;
                    fill_d = '0;
                    if (skid_v_q) begin
                        skid_v_d = 1'b0;
                        data_d   = put_byte('0, skid_lane_q, skid_byte_q);
                        fill_d   = skid_bit;
                        waddr_d  = skid_addr_q;
                        if (fill_d == '1) begin
                            state_d = S_WRITE;
                        end else if (end_d) begin
                            state_d = S_FLUSH;
                        end else begin
                            state_d = S_PACK;
                        end
                    end else begin
                        state_d = end_d ? S_DONE : S_PACK;
                    end
                end
            end
            S_FLUSH: begin
                if (mem_ready) begin
                    data_d  = '0;
                    fill_d  = '0;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                loaded_d[slot_q] = 1'b1;
                mask_d           = calc_mask(cart_q);
                state_d          = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs decoded from state plus registered status.
    always_comb begin
        mem_we      = (state_q == S_WRITE) || (state_q == S_FLUSH);
        ioctl_wait  = (state_q == S_WRITE) || (state_q == S_FLUSH);
        done        = (state_q == S_DONE);
        busy        = (state_q == S_PACK) || (state_q == S_WRITE) || (state_q == S_FLUSH);
        mem_addr    = waddr_q;
        mem_din     = data_q;
        mem_be      = fill_q;
        mem_slot    = slot_q;
        loaded      = loaded_q;
        cart_size   = cart_q;
        mirror_mask = mask_q;
        overflow    = ovf_q;
    end

endmodule
